rptr_sync_decoder: RTL and testbench
====================================

# rptr_sync_decoder

Write-domain receiver for the Gray-coded read pointer of the asynchronous FIFO. Synchronizes the read pointer into `wclk` and forwards the synchronized Gray value to the write-pointer logic for the full compare. Decodes that value back to binary and derives the FIFO fill level and an almost-full flag. Checks that the crossing pointer obeys the one-bit-per-step Gray rule and flags protocol errors.

## Interface

- `PTR_WIDTH`, 3, address bits. Pointers are `PTR_WIDTH+1` bits wide (extra wrap bit). DEPTH = 2^PTR_WIDTH.
- `SYNC_STAGES`, 2, number of synchronizer flops. Legal range is ≥2.
- `AFULL_THRESH`, 6, fill level at which `almost_full` asserts. Legal range is 1..DEPTH.

Ports:

- `wclk` in 1: write clock.
- `wrst_n` in 1: asynchronous, active-low reset.
- `g_rptr` in PTR_WIDTH+1: Gray read pointer, launched from the read clock domain.
- `b_wptr` in PTR_WIDTH+1: binary write pointer, registered in `wclk`.
- `g_rptr_sync` out PTR_WIDTH+1: synchronized Gray read pointer, driven by the last synchronizer flop.
- `b_rptr_sync` out PTR_WIDTH+1: registered binary decode of `g_rptr_sync`.
- `wcount` out PTR_WIDTH+1: registered fill level, range 0..DEPTH.
- `almost_full` out 1: registered; 1 when the fill level is ≥ AFULL_THRESH.
- `gray_err` out 1: sticky; a synchronized pointer step changed more than one bit.
- `ptr_err` out 1: sticky; the computed fill level exceeded DEPTH.

## Operation

- **Synchronizer**
  - `g_rptr` is sampled through a chain of SYNC_STAGES flops. No logic sits between the stages.
  - `g_rptr_sync` is the output of the last stage.
- **Decode**
  - Combinational Gray-to-binary conversion on `g_rptr_sync`: bit[MSB] = g[MSB]; bit[i] = bit[i+1] ^ g[i].
  - The result is registered into `b_rptr_sync`.
- **Fill level**
  - `cnt_next = (b_wptr - decode(g_rptr_sync))` modulo 2^(PTR_WIDTH+1), unsigned.
  - This arithmetic handles wrap automatically; the wrap bit differing means the writer is a lap ahead.
  - `wcount` registers `cnt_next`.
  - `almost_full` registers `(cnt_next >= AFULL_THRESH)`.
- **Gray check**
  - Each cycle, compare the incoming last-stage value with the current `g_rptr_sync`.
  - If popcount(XOR) > 1, set `gray_err`.
  - A zero- or one-bit change is legal.
- **Bound check**
  - If `cnt_next > DEPTH`, set `ptr_err`.
  - `wcount` still registers the raw value; it is not clamped.
- **Sticky flags**: both error flags clear only on reset.
- **Count direction**: `wcount` is pessimistic. It can only overstate occupancy, because the read pointer seen in `wclk` is stale. It never understates.

## Timing

- **Reset**: all flops (synchronizer stages included) and all outputs are 0 while `wrst_n`=0. Assertion is asynchronous; deassertion is taken on the next `wclk` rising edge.
- **Reset mid-operation**
  - Outputs drop to 0 immediately.
  - After release, the pipeline refills from the live `g_rptr`.
  - No `gray_err` may be raised by the jump from the reset value 0 to the live pointer during the first SYNC_STAGES+1 cycles after release. A post-reset qualifier counter masks the check for this window.
- **Latency**, from a `g_rptr` change stable before wclk edge N:
  - `g_rptr_sync` updates at edge N+SYNC_STAGES−1.
  - `b_rptr_sync`, `wcount`, and `almost_full` update one edge later.
- **`b_wptr` change**: reaches `wcount` and `almost_full` at the next edge (1-cycle latency).
- **Simultaneous changes**: when `b_wptr` and `g_rptr_sync` change in the same cycle, both new values are used in the same `cnt_next`.
- **Flag lag**: `almost_full` deassertion lags the actual read by SYNC_STAGES+1 wclk cycles.

## Test plan

- **Reset values**: hold `wrst_n`=0 with `g_rptr`=4'b0110 and `b_wptr`=5.
  - All outputs are 0 during reset.
  - Release with `b_wptr`=5. After the mask window: `g_rptr_sync`=4'b0110, `b_rptr_sync`=4, `wcount`=1, `gray_err`=0.
- **Latency**: step `g_rptr` from 0000 to 0001 before edge N.
  - `g_rptr_sync`=0001 at edge N+1.
  - `b_rptr_sync`=1 at edge N+2.
  - With `b_wptr`=3, `wcount`=2 at edge N+2.
- **Threshold**: read pointer 0, sweep `b_wptr` 5→6→8.
  - `wcount` goes 5/6/8.
  - `almost_full` goes 0/1/1.
  - `ptr_err` stays 0.
- **Wrap**: `b_wptr`=4'b0010, Gray read pointer = gray(14)=4'b1001.
  - `b_rptr_sync`=14, `wcount`=4, `almost_full`=0.
- **Gray error**: after steady `g_rptr`=0000, drive 0011.
  - `gray_err`=1 two edges later.
  - Stays 1 after `g_rptr` returns to legal steps; clears only on reset.
- **Bound error**: read pointer 0, `b_wptr`=9.
  - `wcount`=9 and `ptr_err`=1 on the next edge.
  - `ptr_err` is sticky until `wrst_n` pulses low.

Source files
------------

// File: rtl/rptr_sync_decoder.sv
// rptr_sync_decoder
// Write-domain receiver for the asynchronous FIFO's Gray read pointer.
// It synchronizes the pointer into wclk, decodes it to binary, and derives
// the fill level and almost-full flag from the binary write pointer.
// Because the read pointer seen here is always stale, wcount can overstate
// occupancy but never understate it.
// Two sticky error flags are also raised. gray_err flags a synchronized
// step that changed more than one bit. ptr_err flags a fill level above
// DEPTH. Both flags clear only on reset.

module rptr_sync_decoder #(
  parameter int PTR_WIDTH    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [PTR_WIDTH:0]   g_rptr,
  input  logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_rptr_sync,
  output logic [PTR_WIDTH:0]   b_rptr_sync,
  output logic [PTR_WIDTH:0]   wcount,
  output logic                 almost_full,
  output logic                 gray_err,
  output logic                 ptr_err
);

  localparam int PW1 = PTR_WIDTH + 1;

  // DEPTH itself fits in the pointer width thanks to the extra wrap bit.
  localparam logic [PTR_WIDTH:0] DEPTH_VAL = PW1'(1 << PTR_WIDTH);
  localparam logic [PTR_WIDTH:0] AFULL_VAL = PW1'(AFULL_THRESH);

  // The gray check is masked for SYNC_STAGES+1 edges after reset release.
  // This hides the jump from the reset value 0 to the live pointer.
  localparam int                QUAL_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [QUAL_W-1:0] QUAL_LOAD = QUAL_W'(SYNC_STAGES + 1);

  // sync_q[0] is the first (metastability-catching) stage.
  // sync_q[SYNC_STAGES-1] is the last stage.
  logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q;
  logic [PTR_WIDTH:0]                  g_rptr_pre;
  logic [PTR_WIDTH:0]                  b_dec;
  logic [PTR_WIDTH:0]                  cnt_next;
  logic [PTR_WIDTH:0]                  gray_step;
  logic                                gray_multi;
  logic [QUAL_W-1:0]                   qual_cnt;
  logic                                gray_chk_en;

  // Plain flop chain with no logic between the stages.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], g_rptr};
    end
  end

  assign g_rptr_sync = sync_q[SYNC_STAGES-1];

  // g_rptr_pre is the value the last stage takes at the next edge.
  assign g_rptr_pre  = sync_q[SYNC_STAGES-2];

  // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    b_dec = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      b_dec[i] = ^(g_rptr_sync >> i);
    end
  end

  // Modulo subtraction absorbs pointer wrap.
  // A differing wrap bit means the writer is one lap ahead.
  assign cnt_next = b_wptr - b_dec;

  // A step is illegal when more than one bit toggles.
  // x & (x-1) clears the lowest set bit, so any remaining bit means two or more changed.
  assign gray_step  = g_rptr_pre ^ g_rptr_sync;
  assign gray_multi = |(gray_step & (gray_step - PW1'(1)));

  // Post-reset qualifier: down-counter, the check is enabled at terminal count 0.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      qual_cnt <= QUAL_LOAD;
    end else if (qual_cnt != '0) begin
      qual_cnt <= qual_cnt - QUAL_W'(1);
    end
  end

  assign gray_chk_en = (qual_cnt == '0);

  // Register the decoded pointer, the raw (unclamped) fill level and the almost-full compare.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_rptr_sync <= '0;
      wcount      <= '0;
      almost_full <= 1'b0;
    end else begin
      b_rptr_sync <= b_dec;
      wcount      <= cnt_next;
      almost_full <= (cnt_next >= AFULL_VAL);
    end
  end

  // Sticky protocol flags; only reset clears them.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      gray_err <= 1'b0;
      ptr_err  <= 1'b0;
    end else begin
      if (gray_chk_en && gray_multi) begin
        gray_err <= 1'b1;
      end
      if (cnt_next > DEPTH_VAL) begin
        ptr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rptr_sync_decoder.sv
// tb_rptr_sync_decoder
// The reference model works from the input history sampled at each edge.
// On every edge out of reset it pushes the expected outputs into a queue.
// A separate monitor pops one entry per edge and compares it with the DUT.
// Directed sequences cover reset, latency, threshold, wrap and both error flags.
// Randomized rounds then follow, including some asynchronous mid-run resets.
`timescale 1ns/1ps

module tb_rptr_sync_decoder;

  localparam int PW    = 3;
  localparam int S     = 2;
  localparam int AF    = 6;
  localparam int DEPTH = 8;

  logic       wclk   = 1'b0;
  logic       wrst_n = 1'b0;
  logic [3:0] g_rptr = 4'b0110;
  logic [3:0] b_wptr = 4'd5;
  logic [3:0] g_rptr_sync;
  logic [3:0] b_rptr_sync;
  logic [3:0] wcount;
  logic       almost_full;
  logic       gray_err;
  logic       ptr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gs;
    logic [3:0] bs;
    logic [3:0] wc;
    logic       af;
    logic       ge;
    logic       pe;
  } exp_t;

  exp_t sb[$];

  // model state
  int         m_e = 0;
  logic [3:0] m_gin[$];
  logic [3:0] m_gs_prev = 4'd0;
  logic       m_ge = 1'b0;
  logic       m_pe = 1'b0;

  always #5 wclk = ~wclk;

  rptr_sync_decoder #(
    .PTR_WIDTH   (PW),
    .SYNC_STAGES (S),
    .AFULL_THRESH(AF)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .g_rptr     (g_rptr),
    .b_wptr     (b_wptr),
    .g_rptr_sync(g_rptr_sync),
    .b_rptr_sync(b_rptr_sync),
    .wcount     (wcount),
    .almost_full(almost_full),
    .gray_err   (gray_err),
    .ptr_err    (ptr_err)
  );

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [3:0] g);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) v = v ^ (int'(g) >> i);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gs"}, 32'(g_rptr_sync), 32'd0);
    check({tag, "_bs"}, 32'(b_rptr_sync), 32'd0);
    check({tag, "_wc"}, 32'(wcount), 32'd0);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_ge"}, 32'(gray_err), 32'd0);
    check({tag, "_pe"}, 32'(ptr_err), 32'd0);
  endtask

  // Reference model: output at edge e follows from the inputs sampled at edges <= e.
  initial begin
    forever begin
      @(posedge wclk);
      if (!wrst_n) begin
        m_e       = 0;
        m_gin.delete();
        m_gs_prev = 4'd0;
        m_ge      = 1'b0;
        m_pe      = 1'b0;
      end else begin
        exp_t       x;
        logic [3:0] gs;
        int         rb;
        int         wc;
        m_gin.push_back(g_rptr);
        gs = (m_e >= S - 1) ? m_gin[m_e - (S - 1)] : 4'd0;
        rb = from_gray(m_gs_prev);
        wc = (int'(b_wptr) - rb) & 15;
        if (m_e >= S + 1 && $countones(gs ^ m_gs_prev) > 1) m_ge = 1'b1;
        if (wc > DEPTH) m_pe = 1'b1;
        x.gs = gs;
        x.bs = 4'(rb);
        x.wc = 4'(wc);
        x.af = (wc >= AF);
        x.ge = m_ge;
        x.pe = m_pe;
        sb.push_back(x);
        m_gs_prev = gs;
        m_e++;
      end
    end
  end

  // Monitor: one DUT output per edge, checked just after the edge.
  initial begin
    forever begin
      @(posedge wclk);
      #1;
      if (!wrst_n) begin
        check_all_zero("mon_rst");
      end else if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        check("sb_gs", 32'(g_rptr_sync), 32'(x.gs));
        check("sb_bs", 32'(b_rptr_sync), 32'(x.bs));
        check("sb_wc", 32'(wcount), 32'(x.wc));
        check("sb_af", 32'(almost_full), 32'(x.af));
        check("sb_ge", 32'(gray_err), 32'(x.ge));
        check("sb_pe", 32'(ptr_err), 32'(x.pe));
      end
    end
  end

  task automatic after_edges(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] g, input logic [3:0] w);
    @(negedge wclk);
    g_rptr = g;
    b_wptr = w;
    #2 wrst_n = 1'b0;
    #1 check_all_zero("rst_async");
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] w;
    logic [3:0] d;

    // reset values
    repeat (3) @(negedge wclk);
    check_all_zero("rst_hold");
    wrst_n = 1'b1;
    after_edges(5);
    check("rst_gs", 32'(g_rptr_sync), 32'h6);
    check("rst_bs", 32'(b_rptr_sync), 32'd4);
    check("rst_wc", 32'(wcount), 32'd1);
    check("rst_ge", 32'(gray_err), 32'd0);

    // latency
    do_reset(4'b0000, 4'd3);
    after_edges(4);
    @(negedge wclk);
    g_rptr = 4'b0001;
    after_edges(1);
    check("lat_gs_n", 32'(g_rptr_sync), 32'd0);
    after_edges(1);
    check("lat_gs_n1", 32'(g_rptr_sync), 32'd1);
    check("lat_wc_n1", 32'(wcount), 32'd3);
    after_edges(1);
    check("lat_bs_n2", 32'(b_rptr_sync), 32'd1);
    check("lat_wc_n2", 32'(wcount), 32'd2);

    // threshold sweep with read pointer 0
    @(negedge wclk);
    g_rptr = 4'b0000;
    after_edges(4);
    @(negedge wclk); b_wptr = 4'd5;
    after_edges(1);
    check("thr_wc5", 32'(wcount), 32'd5);
    check("thr_af5", 32'(almost_full), 32'd0);
    @(negedge wclk); b_wptr = 4'd6;
    after_edges(1);
    check("thr_wc6", 32'(wcount), 32'd6);
    check("thr_af6", 32'(almost_full), 32'd1);
    @(negedge wclk); b_wptr = 4'd8;
    after_edges(1);
    check("thr_wc8", 32'(wcount), 32'd8);
    check("thr_af8", 32'(almost_full), 32'd1);
    check("thr_pe8", 32'(ptr_err), 32'd0);

    // bound error, sticky
    @(negedge wclk); b_wptr = 4'd9;
    after_edges(1);
    check("bnd_wc9", 32'(wcount), 32'd9);
    check("bnd_pe", 32'(ptr_err), 32'd1);
    @(negedge wclk); b_wptr = 4'd3;
    after_edges(3);
    check("bnd_pe_sticky", 32'(ptr_err), 32'd1);
    check("bnd_wc3", 32'(wcount), 32'd3);

    // wrap
    do_reset(4'b1001, 4'b0010);
    after_edges(5);
    check("wrap_bs", 32'(b_rptr_sync), 32'd14);
    check("wrap_wc", 32'(wcount), 32'd4);
    check("wrap_af", 32'(almost_full), 32'd0);
    check("wrap_pe", 32'(ptr_err), 32'd0);

    // gray error, sticky
    do_reset(4'b0000, 4'd0);
    after_edges(5);
    @(negedge wclk); g_rptr = 4'b0011;
    after_edges(1);
    check("gray_ge_n", 32'(gray_err), 32'd0);
    after_edges(1);
    check("gray_ge_n1", 32'(gray_err), 32'd1);
    @(negedge wclk); g_rptr = 4'b0010;
    @(negedge wclk); g_rptr = 4'b0110;
    @(negedge wclk); g_rptr = 4'b0111;
    after_edges(3);
    check("gray_ge_sticky", 32'(gray_err), 32'd1);
    do_reset(4'b0111, 4'd5);
    after_edges(5);
    check("gray_ge_clr", 32'(gray_err), 32'd0);

    // randomized rounds
    for (int round = 0; round < 6; round++) begin
      r = 4'($urandom_range(0, 15));
      w = r + 4'($urandom_range(0, 8));
      do_reset(to_gray(r), w);
      for (int cyc = 0; cyc < 150; cyc++) begin
        @(negedge wclk);
        if ($urandom_range(0, 2) == 0 && r != w) r = r + 4'd1;
        d = w - r;
        if ($urandom_range(0, 2) == 0 && d < 4'd9) w = w + 4'd1;
        if ($urandom_range(0, 60) == 0) w = w + 4'd2;
        b_wptr = w;
        g_rptr = to_gray(r);
        if ($urandom_range(0, 80) == 0) g_rptr = 4'($urandom_range(0, 15));
        if ((round % 2) == 1 && cyc == 75) begin
          do_reset(to_gray(r), w);
        end
      end
    end

    after_edges(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
